// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: branch opcodes, EX/MEM bundle widths,
// skid-buffer state encoding and the branch-condition helper.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CTRL_W     = 3;  // reg_write, mem_read, mem_write

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b001;
    localparam logic [2:0] BR_NE   = 3'b010;
    localparam logic [2:0] BR_LT   = 3'b011;
    localparam logic [2:0] BR_GE   = 3'b100;
    localparam logic [2:0] BR_JAL  = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } buf_state_t;

    // Encodings 110/111 fall through to not-taken.
    function automatic logic br_taken(input logic [2:0] op, input logic zero, input logic less);
        logic taken;
        taken = 1'b0;
        case (op)
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            BR_LT:   taken = less;
            BR_GE:   taken = ~less;
            BR_JAL:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ex_mem_entry.sv
// One enable-loaded storage slot for the flattened EX/MEM bundle.
module ex_mem_entry #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM stage: 2-entry skid buffer for the ALU bundle plus branch resolution
// with a registered one-cycle PC redirect.
module ex_mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_W     = XLEN,
    parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_less,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            br_op,
    input  logic [DATA_W-1:0]     br_target,
    input  logic [DATA_W-1:0]     pc_plus4,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  redirect_valid,
    output logic [DATA_W-1:0]     redirect_pc,
    input  logic                  flush
);

    localparam int unsigned BW = 2 * DATA_W + REG_ADDR_W + CTRL_W;

    buf_state_t state, next_state;
    logic in_ready_q;
    logic accept, deliver;
    logic load_main, load_skid, main_from_skid;
    logic [BW-1:0] in_bundle, main_d, main_q, skid_q;
    logic [DATA_W-1:0] in_result;
    logic redir_q;
    logic [DATA_W-1:0] redir_pc_q;

    assign accept  = in_valid & in_ready_q;
    assign deliver = out_valid & out_ready;

    assign in_result = (br_op == BR_JAL) ? pc_plus4 : alu_result;
    assign in_bundle = {in_result, store_data, rd, reg_write, mem_read, mem_write};
    assign main_d    = main_from_skid ? skid_q : in_bundle;

    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    next_state = ST_ONE;
                    load_main  = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !deliver) begin
                    next_state = ST_FULL;
                    load_skid  = 1'b1;
                end else if (!accept && deliver) begin
                    next_state = ST_EMPTY;
                end else if (accept && deliver) begin
                    load_main = 1'b1;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    next_state     = ST_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
        if (flush) begin
            next_state = ST_EMPTY;
            load_main  = 1'b0;
            load_skid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
            redir_q    <= 1'b0;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state != ST_FULL);
            redir_q    <= accept & ~flush & br_taken(br_op, alu_zero, alu_less);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            redir_pc_q <= br_target;
        end
    end

    ex_mem_entry #(.W(BW)) u_main (
        .clk (clk),
        .en  (load_main),
        .d   (main_d),
        .q   (main_q)
    );

    ex_mem_entry #(.W(BW)) u_skid (
        .clk (clk),
        .en  (load_skid),
        .d   (in_bundle),
        .q   (skid_q)
    );

    // Data slots are not reset, so every output is gated by its valid bit.
    assign out_valid      = (state != ST_EMPTY);
    assign in_ready       = in_ready_q;
    assign out_result     = out_valid ? main_q[BW-1 -: DATA_W] : '0;
    assign out_store_data = out_valid ? main_q[BW-DATA_W-1 -: DATA_W] : '0;
    assign out_rd         = out_valid ? main_q[CTRL_W +: REG_ADDR_W] : '0;
    assign out_reg_write  = out_valid & main_q[2];
    assign out_mem_read   = out_valid & main_q[1];
    assign out_mem_write  = out_valid & main_q[0];
    assign redirect_valid = redir_q;
    assign redirect_pc    = redir_q ? redir_pc_q : '0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [31:0] alu_result, store_data, br_target, pc_plus4;
    logic        alu_zero, alu_less;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write;
    logic [2:0]  br_op;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_store_data, redirect_pc;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write, redirect_valid, flush;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less),
        .store_data(store_data), .rd(rd), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .br_op(br_op),
        .br_target(br_target), .pc_plus4(pc_plus4), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result),
        .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; alu_result = '0; alu_zero = 0; alu_less = 0; store_data = '0;
        rd = '0; reg_write = 0; mem_read = 0; mem_write = 0; br_op = 3'b000;
        br_target = '0; pc_plus4 = '0; flush = 0; rst = 0;
    endtask

    task automatic put(input logic [31:0] res, input logic [4:0] r, input logic [2:0] op,
                       input logic z, input logic l, input logic [31:0] tgt);
        in_valid = 1; alu_result = res; rd = r; reg_write = (op == 3'b000);
        br_op = op; alu_zero = z; alu_less = l; br_target = tgt;
        store_data = res ^ 32'hFFFF_0000; pc_plus4 = 32'h44;
    endtask

    initial begin
        idle();
        out_ready = 1;
        rst = 1;
        step(); step();
        rst = 0;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_redirect", {31'b0, redirect_valid}, 32'd0);
        check("rst_result", out_result, 32'd0);

        // Pass-through
        put(32'h7, 5'd5, 3'b000, 0, 0, 32'h0);
        step(); idle();
        check("pt_valid", {31'b0, out_valid}, 32'd1);
        check("pt_result", out_result, 32'h7);
        check("pt_rd", {27'b0, out_rd}, 32'd5);
        check("pt_regwr", {31'b0, out_reg_write}, 32'd1);
        check("pt_store", out_store_data, 32'hFFFF_0007);
        check("pt_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("pt_drained", {31'b0, out_valid}, 32'd0);
        check("pt_regwr_gated", {31'b0, out_reg_write}, 32'd0);

        // Backpressure A,B,C
        out_ready = 0;
        put(32'hA, 5'd1, 3'b000, 0, 0, 32'h0);
        step();
        check("bp_one_ready", {31'b0, in_ready}, 32'd1);
        put(32'hB, 5'd2, 3'b000, 0, 0, 32'h0);
        step();
        check("bp_full_ready", {31'b0, in_ready}, 32'd0);
        check("bp_head_a", out_result, 32'hA);
        put(32'hC, 5'd3, 3'b000, 0, 0, 32'h0);
        step();
        check("bp_stall_ready", {31'b0, in_ready}, 32'd0);
        check("bp_stall_head", out_result, 32'hA);
        out_ready = 1;
        step();
        check("bp_b", out_result, 32'hB);
        check("bp_b_rd", {27'b0, out_rd}, 32'd2);
        check("bp_ready_back", {31'b0, in_ready}, 32'd1);
        step(); idle();
        check("bp_c", out_result, 32'hC);
        check("bp_c_rd", {27'b0, out_rd}, 32'd3);
        step();
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // BEQ taken, then one-cycle check
        put(32'h0, 5'd0, 3'b001, 1, 0, 32'h100);
        step(); idle();
        check("beq_redir", {31'b0, redirect_valid}, 32'd1);
        check("beq_pc", redirect_pc, 32'h100);
        check("beq_regwr", {31'b0, out_reg_write}, 32'd0);
        step();
        check("beq_pulse_end", {31'b0, redirect_valid}, 32'd0);
        put(32'h5, 5'd0, 3'b001, 0, 0, 32'h100);
        step(); idle();
        check("beq_not_taken", {31'b0, redirect_valid}, 32'd0);
        put(32'h0, 5'd0, 3'b010, 0, 0, 32'h180);
        step(); idle();
        check("bne_taken", {31'b0, redirect_valid}, 32'd1);
        check("bne_pc", redirect_pc, 32'h180);
        put(32'hFFFF_FFFF, 5'd0, 3'b011, 0, 1, 32'h200);
        step(); idle();
        check("blt_taken", {31'b0, redirect_valid}, 32'd1);
        check("blt_pc", redirect_pc, 32'h200);
        put(32'hFFFF_FFFF, 5'd0, 3'b100, 0, 1, 32'h300);
        step(); idle();
        check("bge_not_taken", {31'b0, redirect_valid}, 32'd0);
        put(32'h0, 5'd0, 3'b110, 1, 1, 32'h400);
        step(); idle();
        check("op110_none", {31'b0, redirect_valid}, 32'd0);
        check("op110_result", out_result, 32'h0);

        // Redirect raised even when MEM stalls
        out_ready = 0;
        put(32'h0, 5'd0, 3'b001, 1, 0, 32'h140);
        step(); idle();
        check("stall_redir", {31'b0, redirect_valid}, 32'd1);
        out_ready = 1;
        step();

        // JAL
        put(32'hDEAD, 5'd1, 3'b101, 0, 0, 32'h800);
        reg_write = 1;
        step(); idle();
        check("jal_result", out_result, 32'h44);
        check("jal_redir", {31'b0, redirect_valid}, 32'd1);
        check("jal_pc", redirect_pc, 32'h800);
        step();

        // Flush from FULL with a taken branch presented
        out_ready = 0;
        put(32'h11, 5'd1, 3'b000, 0, 0, 32'h0); step();
        put(32'h22, 5'd2, 3'b000, 0, 0, 32'h0); step();
        check("fl_full", {31'b0, in_ready}, 32'd0);
        put(32'h0, 5'd0, 3'b001, 1, 0, 32'h500);
        flush = 1;
        step(); idle();
        check("fl_full_valid", {31'b0, out_valid}, 32'd0);
        check("fl_full_ready", {31'b0, in_ready}, 32'd1);
        check("fl_full_redir", {31'b0, redirect_valid}, 32'd0);

        // Flush from ONE: the branch is accept-eligible but must be discarded
        put(32'h33, 5'd3, 3'b000, 0, 0, 32'h0); step();
        put(32'h0, 5'd0, 3'b101, 0, 0, 32'h600);
        flush = 1;
        step(); idle();
        check("fl_one_valid", {31'b0, out_valid}, 32'd0);
        check("fl_one_ready", {31'b0, in_ready}, 32'd1);
        check("fl_one_redir", {31'b0, redirect_valid}, 32'd0);
        step();
        check("fl_one_stays_empty", {31'b0, out_valid}, 32'd0);

        // Reset mid-stream
        put(32'h44, 5'd4, 3'b000, 0, 0, 32'h0); step();
        put(32'h55, 5'd5, 3'b000, 0, 0, 32'h0); step();
        put(32'h0, 5'd0, 3'b001, 1, 0, 32'h700);
        rst = 1;
        step(); idle();
        check("rs_valid", {31'b0, out_valid}, 32'd0);
        check("rs_ready", {31'b0, in_ready}, 32'd1);
        check("rs_redir", {31'b0, redirect_valid}, 32'd0);

        // Recovery after reset
        out_ready = 1;
        put(32'h99, 5'd9, 3'b000, 0, 0, 32'h0);
        step(); idle();
        check("rec_result", out_result, 32'h99);
        check("rec_rd", {27'b0, out_rd}, 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
